// File: rtl/thread_state_mux_if.sv
// Bundle of write-channel, read-port and status signals for the per-thread
// state table. The master side (schedulers/FSMs) drives requests and read
// indices; the slave side (the table) returns busy, read data and status.
interface thread_state_mux_if #(
  parameter int N_WR    = 4,
  parameter int N_RD    = 4,
  parameter int IDX_W   = 4,
  parameter int STATE_W = 4,
  parameter int CNT_W   = 5
);
  logic [N_WR-1:0]         wr_en;
  logic [N_WR*IDX_W-1:0]   wr_num;
  logic [N_WR*STATE_W-1:0] wr_state;
  logic [N_WR-1:0]         wr_busy;
  logic [N_RD*IDX_W-1:0]   rd_num;
  logic [N_RD*STATE_W-1:0] rd_state;
  logic                    init_done;
  logic [CNT_W-1:0]        match_cnt;
  logic [2:0]              err;

  modport master (
    output wr_en, wr_num, wr_state, rd_num,
    input  wr_busy, rd_state, init_done, match_cnt, err
  );

  modport slave (
    input  wr_en, wr_num, wr_state, rd_num,
    output wr_busy, rd_state, init_done, match_cnt, err
  );
endinterface

// File: rtl/thread_state_mux.sv
// Per-thread state table: N_WR write channels feed 1-deep holding registers
// that commit one at a time (lowest channel first) into a distributed-RAM
// table. Self-initialises after reset, serves N_RD read ports and tracks how
// many entries currently equal MATCH_STATE.
module thread_state_mux #(
  parameter int N_THREADS   = 16,
  parameter int STATE_W     = 4,
  parameter int N_WR        = 4,
  parameter int N_RD        = 4,
  parameter bit ASYNC_RD0   = 1'b1,
  parameter int INIT_STATE  = 0,
  parameter int MATCH_STATE = 1,
  parameter int MAX_WAIT    = 15
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  thread_state_mux_if.slave   bus
);
  localparam int IDX_W  = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;
  localparam int CNT_W  = IDX_W + 1;
  localparam int PTR_W  = IDX_W + 1;
  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [STATE_W-1:0] INIT_S   = STATE_W'(INIT_STATE);
  localparam logic [STATE_W-1:0] MATCH_S  = STATE_W'(MATCH_STATE);
  localparam logic [PTR_W-1:0]   DEPTH_P  = PTR_W'(N_THREADS);
  localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(N_THREADS);
  localparam logic [WAIT_W-1:0]  MAX_W    = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0]  MAX_W_M1 = WAIT_W'(MAX_WAIT - 1);

  // Index lies inside the table (matters only for non-power-of-2 depths).
  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < DEPTH_P);
  endfunction

  logic [STATE_W-1:0] mem_q [N_THREADS];
  logic [N_WR-1:0]    hold_valid_q, hold_valid_d;
  logic [IDX_W-1:0]   hold_num_q   [N_WR];
  logic [IDX_W-1:0]   hold_num_d   [N_WR];
  logic [STATE_W-1:0] hold_state_q [N_WR];
  logic [STATE_W-1:0] hold_state_d [N_WR];
  logic [WAIT_W-1:0]  wait_q [N_WR];
  logic [WAIT_W-1:0]  wait_d [N_WR];
  logic [2:0]         err_q, err_d;
  logic [PTR_W-1:0]   init_ptr_q, init_ptr_d;
  logic               init_done_q, init_done_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [STATE_W-1:0] rd_q     [N_RD];
  logic [STATE_W-1:0] rd_mem_s [N_RD];
  logic [N_WR-1:0]    busy_s, win_s;
  logic               commit_en_s;
  logic [IDX_W-1:0]   commit_num_s;
  logic [STATE_W-1:0] commit_state_s, commit_old_s;
  logic               mem_we_s;
  logic [IDX_W-1:0]   mem_waddr_s;
  logic [STATE_W-1:0] mem_wdata_s;

  // A channel is busy while its holding register is full or the table is still initialising.
  assign busy_s        = hold_valid_q | {N_WR{~init_done_q}};
  assign bus.wr_busy   = busy_s;
  assign bus.init_done = init_done_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.err       = err_q;

  // Fixed-priority pick of the lowest-index full holding register.
  always_comb begin
    win_s          = '0;
    commit_en_s    = 1'b0;
    commit_num_s   = '0;
    commit_state_s = '0;
    for (int k = 0; k < N_WR; k++) begin
      if (hold_valid_q[k] && !commit_en_s) begin
        win_s[k]       = 1'b1;
        commit_en_s    = 1'b1;
        commit_num_s   = hold_num_q[k];
        commit_state_s = hold_state_q[k];
      end else begin
        win_s[k] = 1'b0;
      end
    end
  end

  // Asynchronous table lookups: read ports and the old value at the commit address.
  always_comb begin
    for (int j = 0; j < N_RD; j++) begin
      if (in_range(bus.rd_num[j*IDX_W +: IDX_W])) begin
        rd_mem_s[j] = mem_q[bus.rd_num[j*IDX_W +: IDX_W]];
      end else begin
        rd_mem_s[j] = '0;
      end
    end
    if (in_range(commit_num_s)) begin
      commit_old_s = mem_q[commit_num_s];
    end else begin
      commit_old_s = '0;
    end
  end

  // Read data out: registered ports, with port 0 optionally taken straight from the table.
  always_comb begin
    for (int j = 0; j < N_RD; j++) begin
      bus.rd_state[j*STATE_W +: STATE_W] = rd_q[j];
    end
    if (ASYNC_RD0) begin
      bus.rd_state[STATE_W-1:0] = rd_mem_s[0];
    end else begin
      bus.rd_state[STATE_W-1:0] = rd_q[0];
    end
  end

  // Next state: init sweep or commit, match counting, wait counters, capture and errors.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_num_d   = hold_num_q;
    hold_state_d = hold_state_q;
    wait_d       = wait_q;
    err_d        = err_q;
    init_ptr_d   = init_ptr_q;
    init_done_d  = init_done_q;
    match_cnt_d  = match_cnt_q;
    mem_we_s     = 1'b0;
    mem_waddr_s  = '0;
    mem_wdata_s  = '0;

    if (!init_done_q) begin
      if (init_ptr_q < DEPTH_P) begin
        mem_we_s    = 1'b1;
        mem_waddr_s = init_ptr_q[IDX_W-1:0];
        mem_wdata_s = INIT_S;
        init_ptr_d  = init_ptr_q + PTR_W'(1'b1);
        if (INIT_S == MATCH_S) begin
          match_cnt_d = match_cnt_q + CNT_W'(1'b1);
        end else begin
          match_cnt_d = match_cnt_q;
        end
      end else begin
        init_done_d = 1'b1;
      end
    end else if (commit_en_s && in_range(commit_num_s)) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = commit_num_s;
      mem_wdata_s = commit_state_s;
      if ((commit_state_s == MATCH_S) && (commit_old_s != MATCH_S) && (match_cnt_q != DEPTH_C)) begin
        match_cnt_d = match_cnt_q + CNT_W'(1'b1);
      end else if ((commit_state_s != MATCH_S) && (commit_old_s == MATCH_S) && (match_cnt_q != '0)) begin
        match_cnt_d = match_cnt_q - CNT_W'(1'b1);
      end else begin
        match_cnt_d = match_cnt_q;
      end
    end else begin
      mem_we_s = 1'b0;
    end

    for (int k = 0; k < N_WR; k++) begin
      if (win_s[k]) begin
        hold_valid_d[k] = 1'b0;
        wait_d[k]       = '0;
      end else if (hold_valid_q[k]) begin
        if (wait_q[k] != MAX_W) begin
          wait_d[k] = wait_q[k] + WAIT_W'(1'b1);
          if (wait_q[k] == MAX_W_M1) begin
            err_d[2] = 1'b1;
          end else begin
            err_d[2] = err_d[2];
          end
        end else begin
          wait_d[k] = wait_q[k];
        end
      end else begin
        wait_d[k] = '0;
      end

      if (bus.wr_en[k]) begin
        if (!busy_s[k]) begin
          hold_valid_d[k] = 1'b1;
          hold_num_d[k]   = bus.wr_num[k*IDX_W +: IDX_W];
          hold_state_d[k] = bus.wr_state[k*STATE_W +: STATE_W];
        end else if (!init_done_q) begin
          err_d[1] = 1'b1;
        end else begin
          err_d[0] = 1'b1;
        end
      end else begin
        hold_valid_d[k] = hold_valid_d[k];
      end
    end
  end

  // Control and read registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hold_valid_q <= '0;
      err_q        <= 3'b000;
      init_ptr_q   <= '0;
      init_done_q  <= 1'b0;
      match_cnt_q  <= '0;
      for (int k = 0; k < N_WR; k++) begin
        hold_num_q[k]   <= '0;
        hold_state_q[k] <= '0;
        wait_q[k]       <= '0;
      end
      for (int j = 0; j < N_RD; j++) begin
        rd_q[j] <= '0;
      end
    end else begin
      hold_valid_q <= hold_valid_d;
      err_q        <= err_d;
      init_ptr_q   <= init_ptr_d;
      init_done_q  <= init_done_d;
      match_cnt_q  <= match_cnt_d;
      for (int k = 0; k < N_WR; k++) begin
        hold_num_q[k]   <= hold_num_d[k];
        hold_state_q[k] <= hold_state_d[k];
        wait_q[k]       <= wait_d[k];
      end
      for (int j = 0; j < N_RD; j++) begin
        rd_q[j] <= rd_mem_s[j];
      end
    end
  end

  // Table write port; nothing is written while reset is asserted, so pending holds are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end
endmodule

// File: tb/tb_thread_state_mux.sv
// Bench for thread_state_mux with N_THREADS=16, INIT_STATE=MATCH_STATE=1.
// A behavioural model (plain arrays, match count recomputed by scanning the
// table) is compared against the outputs every cycle; directed scenarios add
// hand-computed literal expectations.
module tb_thread_state_mux;
  localparam int N = 16, SW = 4, NW = 4, NR = 4, IW = 4;
  localparam int INIT = 1, MATCH = 1, MAXW = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  thread_state_mux_if #(.N_WR(NW), .N_RD(NR), .IDX_W(IW), .STATE_W(SW), .CNT_W(IW+1)) bus ();

  thread_state_mux #(
    .N_THREADS(N), .STATE_W(SW), .N_WR(NW), .N_RD(NR), .ASYNC_RD0(1'b1),
    .INIT_STATE(INIT), .MATCH_STATE(MATCH), .MAX_WAIT(MAXW)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mem [N];
  bit m_known [N];
  bit m_hv [NW];
  int m_hn [NW];
  int m_hs [NW];
  int m_wait [NW];
  bit [2:0] m_err;
  int m_ptr;
  bit m_done;
  int m_rd [NR];
  bit m_rdk [NR];
  bit started = 1'b0;

  function automatic int model_match();
    int c = 0;
    for (int i = 0; i < N; i++)
      if ((m_done || i < m_ptr) && m_mem[i] == MATCH) c++;
    return c;
  endfunction

  always @(posedge clk) begin
    bit busy [NW];
    bit done_pre;
    int w;
    int idx;
    started = 1'b1;
    if (!rst_n) begin
      for (int k = 0; k < NW; k++) begin m_hv[k] = 1'b0; m_wait[k] = 0; end
      for (int j = 0; j < NR; j++) begin m_rd[j] = 0; m_rdk[j] = 1'b1; end
      m_err = 3'b000; m_ptr = 0; m_done = 1'b0;
    end else begin
      for (int j = 0; j < NR; j++) begin
        idx = int'(bus.rd_num[j*IW +: IW]);
        m_rd[j] = m_mem[idx];
        m_rdk[j] = m_known[idx];
      end
      done_pre = m_done;
      for (int k = 0; k < NW; k++) busy[k] = m_hv[k] || !m_done;
      if (!m_done) begin
        if (m_ptr < N) begin m_mem[m_ptr] = INIT; m_known[m_ptr] = 1'b1; m_ptr++; end
        else m_done = 1'b1;
      end else begin
        w = -1;
        for (int k = 0; k < NW; k++) if (m_hv[k] && w < 0) w = k;
        for (int k = 0; k < NW; k++) begin
          if (m_hv[k] && k == w) begin
            m_mem[m_hn[k]] = m_hs[k]; m_known[m_hn[k]] = 1'b1;
            m_hv[k] = 1'b0; m_wait[k] = 0;
          end else if (m_hv[k] && m_wait[k] < MAXW) begin
            m_wait[k]++;
            if (m_wait[k] == MAXW) m_err[2] = 1'b1;
          end
        end
      end
      for (int k = 0; k < NW; k++) begin
        if (bus.wr_en[k]) begin
          if (!busy[k]) begin
            m_hv[k] = 1'b1;
            m_hn[k] = int'(bus.wr_num[k*IW +: IW]);
            m_hs[k] = int'(bus.wr_state[k*SW +: SW]);
          end else if (!done_pre) m_err[1] = 1'b1;
          else m_err[0] = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [NW-1:0] eb;
    int idx;
    if (started) begin
      for (int k = 0; k < NW; k++) eb[k] = m_hv[k] || !m_done;
      chk("wr_busy", bus.wr_busy, eb);
      chk("init_done", bus.init_done, m_done);
      chk("match_cnt", bus.match_cnt, model_match());
      chk("err", bus.err, m_err);
      idx = int'(bus.rd_num[IW-1:0]);
      if (m_known[idx]) chk("rd_state[0]", bus.rd_state[SW-1:0], m_mem[idx]);
      for (int j = 1; j < NR; j++)
        if (m_rdk[j]) chk($sformatf("rd_state[%0d]", j), bus.rd_state[j*SW +: SW], m_rd[j]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input int num, input int st);
    bus.wr_en[ch] = 1'b1;
    bus.wr_num[ch*IW +: IW] = IW'(num);
    bus.wr_state[ch*SW +: SW] = SW'(st);
  endtask

  task automatic wr1(input int ch, input int num, input int st);
    drive(ch, num, st);
    tick();
    bus.wr_en = 4'b0000;
    tick();
  endtask

  task automatic wait_init(output int n);
    n = 0;
    do begin tick(); n++; end while (!bus.init_done && n < 40);
  endtask

  initial begin
    int n;
    bus.wr_en = 4'b0000; bus.wr_num = 16'h0000; bus.wr_state = 16'h0000; bus.rd_num = 16'h0000;

    // Reset and self-initialisation.
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_init_done", bus.init_done, 1'b0);
    chk("rst_match", bus.match_cnt, 5'd0);
    chk("rst_busy", bus.wr_busy, 4'b1111);
    rst_n = 1'b1;
    wait_init(n);
    chk("init_latency", n, 17);
    chk("init_match", bus.match_cnt, 5'd16);
    bus.rd_num = 16'hF830;
    tick();
    chk("init_reads", bus.rd_state, 16'h1111);

    // Two channels on thread 5 in the same cycle.
    bus.rd_num = 16'h0505;
    drive(0, 5, 2); drive(2, 5, 3);
    tick(); bus.wr_en = 4'b0000;
    chk("prio_busy_e0", bus.wr_busy, 4'b0101);
    tick();
    chk("prio_busy_e1", bus.wr_busy, 4'b0100);
    chk("prio_rd0_e1", bus.rd_state[3:0], 4'd2);
    chk("prio_match_e1", bus.match_cnt, 5'd15);
    tick();
    chk("prio_busy_e2", bus.wr_busy, 4'b0000);
    chk("prio_rd0_e2", bus.rd_state[3:0], 4'd3);
    chk("prio_rd2_e2", bus.rd_state[11:8], 4'd2);
    tick();
    chk("prio_rd2_e3", bus.rd_state[11:8], 4'd3);
    wr1(0, 5, 1);
    chk("prio_restore", bus.match_cnt, 5'd16);

    // Write while busy is dropped.
    bus.rd_num = 16'h0003;
    drive(0, 2, 1); drive(1, 3, 4);
    tick(); bus.wr_en = 4'b0000;
    drive(1, 3, 7);
    tick(); bus.wr_en = 4'b0000;
    chk("drop_err", bus.err, 3'b001);
    chk("drop_busy", bus.wr_busy, 4'b0010);
    tick();
    chk("drop_rd0", bus.rd_state[3:0], 4'd4);
    chk("drop_match", bus.match_cnt, 5'd15);
    wr1(1, 3, 1);
    chk("drop_restore", bus.match_cnt, 5'd16);

    // Thread 7 toggled 1->0->1, async port 0 vs registered port 2.
    bus.rd_num = 16'h0707;
    drive(1, 7, 0);
    tick(); bus.wr_en = 4'b0000;
    chk("t7_rd0_cap", bus.rd_state[3:0], 4'd1);
    tick();
    chk("t7_rd0_c0", bus.rd_state[3:0], 4'd0);
    chk("t7_rd2_c0", bus.rd_state[11:8], 4'd1);
    chk("t7_match0", bus.match_cnt, 5'd15);
    tick();
    chk("t7_rd2_l0", bus.rd_state[11:8], 4'd0);
    drive(1, 7, 1);
    tick(); bus.wr_en = 4'b0000;
    tick();
    chk("t7_rd0_c1", bus.rd_state[3:0], 4'd1);
    chk("t7_rd2_c1", bus.rd_state[11:8], 4'd0);
    chk("t7_match1", bus.match_cnt, 5'd16);
    tick();
    chk("t7_rd2_l1", bus.rd_state[11:8], 4'd1);

    // Starvation of channel 3 by alternating channel 0/1 traffic.
    bus.rd_num = 16'h000A;
    for (int i = 0; i < 20; i++) begin
      bus.wr_en = 4'b0000;
      if (i % 2 == 0) drive(0, 9, 1); else drive(1, 9, 1);
      if (i == 0) drive(3, 10, 5);
      tick();
      if (i == 14) chk("wait_err_e14", bus.err[2], 1'b0);
      if (i == 15) chk("wait_err_e15", bus.err[2], 1'b1);
    end
    bus.wr_en = 4'b0000;
    tick();
    chk("wait_busy_e20", bus.wr_busy, 4'b1000);
    tick();
    chk("wait_busy_e21", bus.wr_busy, 4'b0000);
    chk("wait_rd0", bus.rd_state[3:0], 4'd5);
    chk("wait_match", bus.match_cnt, 5'd15);
    chk("wait_err_all", bus.err, 3'b101);

    // Reset with three pending holds, then a write during re-init.
    bus.rd_num = 16'h0007;
    drive(1, 7, 9); drive(2, 8, 10); drive(3, 11, 12);
    tick(); bus.wr_en = 4'b0000;
    chk("rr_busy_pend", bus.wr_busy, 4'b1110);
    rst_n = 1'b0;
    tick();
    chk("rr_busy", bus.wr_busy, 4'b1111);
    chk("rr_err", bus.err, 3'b000);
    chk("rr_match", bus.match_cnt, 5'd0);
    chk("rr_no_commit", bus.rd_state[3:0], 4'd1);
    tick();
    rst_n = 1'b1;
    drive(0, 4, 3);
    tick(); bus.wr_en = 4'b0000;
    chk("rr_init_err", bus.err, 3'b010);
    wait_init(n);
    chk("rr_init_latency", n + 1, 17);
    chk("rr_match_rebuilt", bus.match_cnt, 5'd16);
    chk("rr_rd0", bus.rd_state[3:0], 4'd1);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_err);
    $fatal(1);
  end
endmodule
